mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 192 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative MIPS-style multiply/divide unit with HI/LO registers.
//            Radix-2 shift-add multiply and restoring divide on magnitudes,
//            one step per cycle, sign correction on the final step.
// Revision : 1.0  initial release
// ============================================================================
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [2:0]       OP_MULT   = 3'd0;
  localparam logic [2:0]       OP_DIV    = 3'd2;
  localparam logic [2:0]       OP_MTHI   = 3'd4;
  localparam logic [2:0]       OP_MTLO   = 3'd5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [1:0]         kind_q, kind_d;     // op[1:0] of the arithmetic op in flight
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d; // partial product high / partial remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d; // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0]   b_q, b_d;           // multiplicand or divisor magnitude
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, ready_q, ready_d;

  logic               accept, is_signed_in, is_div_q, is_signed_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   nx_hi, nx_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_raw, prod;

  assign in_ready = ready_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // One radix-2 step of the active algorithm and the sign-corrected result it yields
  always_comb begin
    accept       = in_valid && (state_q == S_IDLE) && !flush;
    is_signed_in = (op == OP_MULT) || (op == OP_DIV);
    a_mag        = (is_signed_in && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag        = (is_signed_in && src_b[WIDTH-1]) ? -src_b : src_b;

    is_div_q     = kind_q[1];
    is_signed_q  = !kind_q[0];

    mul_sum   = {1'b0, acc_hi_q} + ({1'b0, b_q} & {(WIDTH+1){acc_lo_q[0]}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});

    if (is_div_q) begin
      // difference is always below the divisor, so the low WIDTH bits are exact
      nx_hi = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
      nx_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      nx_hi = mul_sum[WIDTH:1];
      nx_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    prod_raw = {nx_hi, nx_lo};
    prod     = (is_signed_q && (sa_q ^ sb_q)) ? -prod_raw : prod_raw;

    if (is_div_q) begin
      // divide by zero: quotient all ones, remainder path naturally returns src_a
      res_lo = (b_q == '0) ? '1 : ((is_signed_q && (sa_q ^ sb_q)) ? -nx_lo : nx_lo);
      res_hi = (is_signed_q && sa_q) ? -nx_hi : nx_hi;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Next-state: accept, iterate, finish; flush returns to IDLE without writing HI/LO
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          kind_d = op[1:0];
          sa_d   = is_signed_in && src_a[WIDTH-1];
          sb_d   = is_signed_in && src_b[WIDTH-1];
          cnt_d  = '0;
          if (op[2]) begin
            // moves and reserved ops complete in one cycle
            state_d = S_FIN;
            done_d  = 1'b1;
            if (op == OP_MTHI) hi_d = src_a;
            if (op == OP_MTLO) lo_d = src_a;
          end else begin
            state_d  = S_BUSY;
            acc_hi_d = '0;
            if (op[1]) begin
              acc_lo_d = a_mag;
              b_d      = b_mag;
            end else begin
              acc_lo_d = b_mag;
              b_d      = a_mag;
            end
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_hi_d = nx_hi;
          acc_lo_d = nx_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            hi_d    = res_hi;
            lo_d    = res_lo;
            cnt_d   = '0;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers, cleared asynchronously by resetn
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      kind_q   <= 2'd0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Self-checking bench for mdu_iter (WIDTH=32 and WIDTH=8 builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        v32, f32, rdy32, dn32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        v8, f8, rdy8, dn8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  mdu_iter #(.WIDTH(32)) u_dut32 (
    .clk(clk), .resetn(resetn), .in_valid(v32), .in_ready(rdy32), .op(op32),
    .src_a(a32), .src_b(b32), .flush(f32), .done(dn32), .hi(hi32), .lo(lo32));

  mdu_iter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .resetn(resetn), .in_valid(v8), .in_ready(rdy8), .op(op8),
    .src_a(a8), .src_b(b8), .flush(f8), .done(dn8), .hi(hi8), .lo(lo8));

  int total = 0;
  int bad   = 0;
  logic [63:0] m_hi [2];
  logic [63:0] m_lo [2];

  typedef struct {
    bit          s;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          fl;
    logic [63:0] eh;
    logic [63:0] el;
    string       nm;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit s, input logic v, input logic [2:0] o,
                       input logic [63:0] a, input logic [63:0] b, input logic f);
    if (s) begin
      v8 = v; op8 = o; a8 = a[7:0]; b8 = b[7:0]; f8 = f;
    end else begin
      v32 = v; op32 = o; a32 = a[31:0]; b32 = b[31:0]; f32 = f;
    end
  endtask

  function automatic logic [63:0] get_hi(input bit s);
    return s ? {56'd0, hi8} : {32'd0, hi32};
  endfunction
  function automatic logic [63:0] get_lo(input bit s);
    return s ? {56'd0, lo8} : {32'd0, lo32};
  endfunction
  function automatic logic get_done(input bit s);
    return s ? dn8 : dn32;
  endfunction
  function automatic logic get_rdy(input bit s);
    return s ? rdy8 : rdy32;
  endfunction

  // Architectural result of one op, from plain integer arithmetic
  function automatic void ref_model(input int w, input logic [2:0] o,
                                    input logic [63:0] a, input logic [63:0] b,
                                    input logic [63:0] h0, input logic [63:0] l0,
                                    output logic [63:0] eh, output logic [63:0] el);
    logic [63:0]     mask;
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = ua[w-1] ? (longint'(ua) - longint'(64'd1 << w)) : longint'(ua);
    sb = ub[w-1] ? (longint'(ub) - longint'(64'd1 << w)) : longint'(ub);
    eh = h0;
    el = l0;
    case (o)
      3'd0: begin sp = sa * sb; eh = (sp >>> w) & mask; el = sp & mask; end
      3'd1: begin up = ua * ub; eh = (up >> w) & mask;  el = up & mask; end
      3'd2: begin
        if (ub == 0) begin el = mask; eh = ua; end
        else begin sp = sa / sb; el = sp & mask; sp = sa % sb; eh = sp & mask; end
      end
      3'd3: begin
        if (ub == 0) begin el = mask; eh = ua; end
        else begin up = ua / ub; el = up & mask; up = ua % ub; eh = up & mask; end
      end
      3'd4: eh = ua;
      3'd5: el = ua;
      default: ;
    endcase
  endfunction

  // Issue one op, watch it cycle by cycle, check timing, stability and result
  task automatic run_op(input bit s, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input int flush_at,
                        input logic [63:0] eh, input logic [63:0] el, input string nm);
    int w, busy_len, lat, dcount;
    bit flushed, stable, inj;
    logic [63:0] h0, l0, xh, xl;
    w        = s ? 8 : 32;
    busy_len = (o <= 3'd3) ? w : 0;
    flushed  = (flush_at >= 1) && (flush_at <= busy_len);
    inj      = (o <= 3'd3) && (flush_at != 1);
    h0 = m_hi[s];
    l0 = m_lo[s];
    lat = 0; dcount = 0; stable = 1'b1;
    @(negedge clk);
    chk($sformatf("%s/ready", nm), {63'd0, get_rdy(s)}, 64'd1);
    drive(s, 1'b1, o, a, b, 1'b0);
    @(posedge clk); #1;
    drive(s, 1'b0, 3'd4, ~a, ~b, 1'b0);
    for (int k = 1; k <= w + 5; k++) begin
      drive(s, inj && (k == 2), 3'd4, ~a, ~b, k == flush_at);
      @(negedge clk);
      if (get_done(s)) begin
        dcount++;
        if (lat == 0) lat = k;
      end
      xh = (dcount > 0) ? eh : h0;
      xl = (dcount > 0) ? el : l0;
      if (get_hi(s) !== xh || get_lo(s) !== xl) stable = 1'b0;
      if (flush_at > 0 && k == flush_at + 1)
        chk($sformatf("%s/ready_after_flush", nm), {63'd0, get_rdy(s)}, 64'd1);
      @(posedge clk); #1;
      drive(s, 1'b0, 3'd4, ~a, ~b, 1'b0);
    end
    chk($sformatf("%s/done_count", nm), dcount, flushed ? 0 : 1);
    if (!flushed) chk($sformatf("%s/latency", nm), lat, busy_len + 1);
    chk($sformatf("%s/hilo_stable", nm), {63'd0, stable}, 64'd1);
    chk($sformatf("%s/hi", nm), get_hi(s), flushed ? h0 : eh);
    chk($sformatf("%s/lo", nm), get_lo(s), flushed ? l0 : el);
    m_hi[s] = flushed ? h0 : eh;
    m_lo[s] = flushed ? l0 : el;
  endtask

  function automatic logic [63:0] rnd_opnd(input int w);
    logic [63:0] mask, v;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = mask;
      2: v = 64'd1 << (w - 1);
      3: v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & mask;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] eh, el;
    logic [2:0]  o;
    int          fl, w;
    bit          seen;

    resetn = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    m_hi[0] = 64'd0; m_lo[0] = 64'd0; m_hi[1] = 64'd0; m_lo[1] = 64'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/hi", {32'd0, hi32}, 64'd0);
    chk("reset/lo", {32'd0, lo32}, 64'd0);
    chk("reset/done", {63'd0, dn32}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset/ready", {63'd0, rdy32}, 64'd1);
    chk("reset/ready8", {63'd0, rdy8}, 64'd1);

    // directed vectors, expectations worked out by hand
    vecs[0]  = '{1'b0, 3'd0, 64'hFFFFFFFE, 64'h3,        0,  64'hFFFFFFFF, 64'hFFFFFFFA, "mult_m2x3"};
    vecs[1]  = '{1'b0, 3'd2, 64'hFFFFFFF9, 64'h2,        0,  64'hFFFFFFFF, 64'hFFFFFFFD, "div_m7d2"};
    vecs[2]  = '{1'b0, 3'd3, 64'h7,        64'h0,        0,  64'h7,        64'hFFFFFFFF, "divu_7d0"};
    vecs[3]  = '{1'b0, 3'd4, 64'h12345678, 64'h0,        0,  64'h12345678, 64'hFFFFFFFF, "mthi"};
    vecs[4]  = '{1'b0, 3'd5, 64'h9ABCDEF0, 64'h0,        0,  64'h12345678, 64'h9ABCDEF0, "mtlo"};
    vecs[5]  = '{1'b0, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 10, 64'h12345678, 64'h9ABCDEF0, "multu_flush10"};
    vecs[6]  = '{1'b0, 3'd2, 64'h80000000, 64'hFFFFFFFF, 0,  64'h0,        64'h80000000, "div_ovf"};
    vecs[7]  = '{1'b0, 3'd2, 64'hFFFFFFF9, 64'h0,        0,  64'hFFFFFFF9, 64'hFFFFFFFF, "div_m7d0"};
    vecs[8]  = '{1'b0, 3'd6, 64'h11111111, 64'h2,        0,  64'hFFFFFFF9, 64'hFFFFFFFF, "reserved6"};
    vecs[9]  = '{1'b0, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 0,  64'hFFFFFFFE, 64'h00000001, "multu_max"};
    vecs[10] = '{1'b0, 3'd0, 64'h7,        64'hFFFFFFFF, 33, 64'hFFFFFFFF, 64'hFFFFFFF9, "mult_flush_fin"};
    vecs[11] = '{1'b1, 3'd2, 64'h80,       64'hFF,       0,  64'h00,       64'h80,       "w8_div_ovf"};
    vecs[12] = '{1'b1, 3'd0, 64'h80,       64'h80,       0,  64'h40,       64'h00,       "w8_mult_min"};
    vecs[13] = '{1'b1, 3'd2, 64'h85,       64'h07,       0,  64'hFC,       64'hEF,       "w8_div_neg"};
    vecs[14] = '{1'b0, 3'd5, 64'h55AA55AA, 64'h0,        1,  64'hFFFFFFFF, 64'h55AA55AA, "mtlo_flush_fin"};
    vecs[15] = '{1'b0, 3'd2, 64'hFFFFFFF9, 64'hFFFFFFFE, 0,  64'hFFFFFFFF, 64'h00000003, "div_m7dm2"};
    for (int i = 0; i < 16; i++)
      run_op(vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fl, vecs[i].eh, vecs[i].el, vecs[i].nm);

    // back-to-back MTHI / MTLO
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd4, 64'h12345678, 64'd0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("b2b/done_c1", {63'd0, dn32}, 64'd1);
    chk("b2b/ready_c1", {63'd0, rdy32}, 64'd0);
    chk("b2b/hi_c1", {32'd0, hi32}, 64'h12345678);
    @(negedge clk);
    chk("b2b/ready_c2", {63'd0, rdy32}, 64'd1);
    drive(1'b0, 1'b1, 3'd5, 64'h9ABCDEF0, 64'd0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("b2b/done_c3", {63'd0, dn32}, 64'd1);
    chk("b2b/ready_c3", {63'd0, rdy32}, 64'd0);
    chk("b2b/hi_c3", {32'd0, hi32}, 64'h12345678);
    chk("b2b/lo_c3", {32'd0, lo32}, 64'h9ABCDEF0);
    @(negedge clk);
    chk("b2b/done_c4", {63'd0, dn32}, 64'd0);
    m_hi[0] = 64'h12345678;
    m_lo[0] = 64'h9ABCDEF0;

    // in_valid together with flush in IDLE is not accepted
    drive(1'b0, 1'b1, 3'd4, 64'hDEADBEEF, 64'd0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("idle_flush/done", {63'd0, dn32}, 64'd0);
    chk("idle_flush/ready", {63'd0, rdy32}, 64'd1);
    chk("idle_flush/hi", {32'd0, hi32}, m_hi[0]);

    // reset in the middle of a DIV
    run_op(1'b0, 3'd4, 64'hA5A5A5A5, 64'd0, 0, 64'hA5A5A5A5, m_lo[0], "mthi_a5");
    run_op(1'b0, 3'd5, 64'hA5A5A5A5, 64'd0, 0, 64'hA5A5A5A5, 64'hA5A5A5A5, "mtlo_a5");
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd2, 64'h64, 64'h7, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_busy/hi_now", {32'd0, hi32}, 64'd0);
    chk("rst_busy/lo_now", {32'd0, lo32}, 64'd0);
    chk("rst_busy/done_now", {63'd0, dn32}, 64'd0);
    m_hi[0] = 64'd0; m_lo[0] = 64'd0; m_hi[1] = 64'd0; m_lo[1] = 64'd0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dn32) seen = 1'b1;
    end
    chk("rst_busy/no_done", {63'd0, seen}, 64'd0);
    chk("rst_busy/hi_after", {32'd0, hi32}, 64'd0);
    run_op(1'b0, 3'd4, 64'h0F0F0F0F, 64'd0, 0, 64'h0F0F0F0F, 64'd0, "post_reset_mthi");

    // randomized ops against the reference model, both widths
    for (int n = 0; n < 1700; n++) begin
      bit s;
      logic [63:0] ra, rb;
      s  = (n >= 200);
      w  = s ? 8 : 32;
      o  = 3'($urandom_range(0, 7));
      ra = rnd_opnd(w);
      rb = rnd_opnd(w);
      fl = 0;
      if ($urandom_range(0, 7) == 0) fl = $urandom_range(1, ((o <= 3'd3) ? w : 0) + 1);
      ref_model(w, o, ra, rb, m_hi[s], m_lo[s], eh, el);
      run_op(s, o, ra, rb, fl, eh, el, $sformatf("rnd%0d_w%0d_op%0d", n, w, o));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
